// File: rtl/oai22_bist_sequencer_if.sv
// Bundle between the OAI22 BIST sequencer (master) and its harness/cell side (slave).
// Carries the run request, the four cell drives, the cell response and the run status.
interface oai22_bist_sequencer_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 start;
    logic                 dut_a1;
    logic                 dut_a2;
    logic                 dut_b1;
    logic                 dut_b2;
    logic                 dut_zn;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [3:0]           first_fail;

    modport master (
        input  start, dut_zn,
        output dut_a1, dut_a2, dut_b1, dut_b2, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, dut_zn,
        input  dut_a1, dut_a2, dut_b1, dut_b2, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/oai22_bist_sequencer.sv
// Sweeps all 16 OAI22 input vectors, samples ZN after SETTLE_CYCLES, counts mismatches; done after
// NUM_PASSES*16*(SETTLE_CYCLES+1) cycles, start ignored while busy. OAI22_BIST_FIRST_FAIL_EN adds first_fail capture.
module oai22_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                   CK,
    input  logic                   RN,
    oai22_bist_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0]           SCNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]           PCNT_LAST = 8'(NUM_PASSES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [3:0]           vec_q, vec_d;
    logic [3:0]           scnt_q, scnt_d;
    logic [7:0]           pcnt_q, pcnt_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [3:0]           drv_q, drv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 golden_zn;
    logic                 mismatch;
`ifdef OAI22_BIST_FIRST_FAIL_EN
    logic [3:0]           ff_q, ff_d;
    logic                 ff_vld_q, ff_vld_d;
`endif

    assign golden_zn = ~((vec_q[0] | vec_q[1]) & (vec_q[2] | vec_q[3]));
    assign mismatch  = (bus.dut_zn != golden_zn);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        scnt_d  = scnt_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
`ifdef OAI22_BIST_FIRST_FAIL_EN
        ff_d     = ff_q;
        ff_vld_d = ff_vld_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    vec_d   = 4'h0;
                    scnt_d  = 4'h0;
                    pcnt_d  = 8'h0;
                    err_d   = '0;
`ifdef OAI22_BIST_FIRST_FAIL_EN
                    ff_d     = 4'h0;
                    ff_vld_d = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (scnt_q == SCNT_LAST) begin
                    scnt_d  = 4'h0;
                    state_d = SAMPLE;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
`ifdef OAI22_BIST_FIRST_FAIL_EN
                    if (!ff_vld_q) begin
                        ff_d     = vec_q;
                        ff_vld_d = 1'b1;
                    end
`endif
                end
                if (vec_q != 4'hF) begin
                    vec_d   = vec_q + 4'd1;
                    state_d = SETTLE;
                end else if (pcnt_q != PCNT_LAST) begin
                    vec_d   = 4'h0;
                    pcnt_d  = pcnt_q + 8'd1;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cell drives are registered so the cell inputs never see decode glitches.
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
        drv_d  = busy_d ? vec_d : 4'h0;
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= IDLE;
            vec_q   <= 4'h0;
            scnt_q  <= 4'h0;
            pcnt_q  <= 8'h0;
            err_q   <= '0;
            drv_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            drv_q   <= drv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef OAI22_BIST_FIRST_FAIL_EN
    always_ff @(posedge CK) begin
        if (!RN) begin
            ff_q     <= 4'h0;
            ff_vld_q <= 1'b0;
        end else begin
            ff_q     <= ff_d;
            ff_vld_q <= ff_vld_d;
        end
    end
    assign bus.first_fail = ff_q;
`else
    assign bus.first_fail = 4'h0;
`endif

    assign bus.dut_a1    = drv_q[0];
    assign bus.dut_a2    = drv_q[1];
    assign bus.dut_b1    = drv_q[2];
    assign bus.dut_b2    = drv_q[3];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_oai22_bist_sequencer.sv
// Bench for oai22_bist_sequencer: a single-pass 8-bit instance and a two-pass 2-bit-counter instance,
// each driving a truth-table cell model.
module tb_oai22_bist_sequencer;
    localparam int SETTLE = 2;

    logic CK;
    logic RN;

    logic [1:0]       start_i;
    logic [1:0][15:0] tt;
    logic [1:0][3:0]  vec_o;
    logic [1:0]       busy_o;
    logic [1:0]       done_o;
    logic [1:0]       pass_o;
    logic [1:0][7:0]  err_o;
    logic [1:0][3:0]  ff_o;

    int tests = 0;
    int fails = 0;

    oai22_bist_sequencer_if #(.ERR_CNT_W(8)) if0 ();
    oai22_bist_sequencer_if #(.ERR_CNT_W(2)) if1 ();

    oai22_bist_sequencer #(.SETTLE_CYCLES(SETTLE), .NUM_PASSES(1), .ERR_CNT_W(8)) u0 (
        .CK (CK),
        .RN (RN),
        .bus(if0.master)
    );

    oai22_bist_sequencer #(.SETTLE_CYCLES(SETTLE), .NUM_PASSES(2), .ERR_CNT_W(2)) u1 (
        .CK (CK),
        .RN (RN),
        .bus(if1.master)
    );

    assign if0.start  = start_i[0];
    assign if1.start  = start_i[1];
    assign vec_o[0]   = {if0.dut_b2, if0.dut_b1, if0.dut_a2, if0.dut_a1};
    assign vec_o[1]   = {if1.dut_b2, if1.dut_b1, if1.dut_a2, if1.dut_a1};
    assign if0.dut_zn = tt[0][vec_o[0]];
    assign if1.dut_zn = tt[1][vec_o[1]];
    assign busy_o     = {if1.busy, if0.busy};
    assign done_o     = {if1.done, if0.done};
    assign pass_o     = {if1.pass, if0.pass};
    assign err_o[0]   = if0.err_count;
    assign err_o[1]   = {6'b0, if1.err_count};
    assign ff_o[0]    = if0.first_fail;
    assign ff_o[1]    = if1.first_fail;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        int          sel;
        logic [15:0] t;
        int          restart_at;
        int          abort_at;
        int          exp_err;
        int          exp_ff;
        int          exp_pass;
        string       name;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // OAI22 truth straight from the boolean definition of the cell.
    function automatic int spec_zn(input int v);
        int a;
        int b;
        a = ((v & 1) != 0 || (v & 2) != 0) ? 1 : 0;
        b = ((v & 4) != 0 || (v & 8) != 0) ? 1 : 0;
        return (a == 1 && b == 1) ? 0 : 1;
    endfunction

    task automatic model(input logic [15:0] t, input int passes, input int satmax,
                         output int e, output int f, output int p);
        int m;
        m = 0;
        f = -1;
        for (int i = 0; i < 16; i++) begin
            if (int'(t[i]) != spec_zn(i)) begin
                m++;
                if (f < 0) f = i;
            end
        end
        e = passes * m;
        if (e > satmax) e = satmax;
        if (f < 0) f = 0;
        p = (m == 0) ? 1 : 0;
    endtask

    task automatic run(input int sel, input logic [15:0] t, input int restart_at, input int abort_at,
                       input int exp_err, input int exp_ff, input int exp_pass, input string tag);
        int passes;
        int n;
        int verr;
        int done_at;
        int ffx;
        passes  = (sel == 1) ? 2 : 1;
        n       = passes * 16 * (SETTLE + 1);
        verr    = 0;
        done_at = -1;
        tt[sel] = t;
        @(negedge CK);
        start_i[sel] = 1'b1;
        @(negedge CK);
        start_i[sel] = 1'b0;
        for (int k = 0; k <= n + 4; k++) begin
            if (k == abort_at) begin
                RN = 1'b0;
                @(negedge CK);
                check({tag, " busy after reset"}, int'(busy_o[sel]), 0);
                check({tag, " drive after reset"}, int'(vec_o[sel]), 0);
                check({tag, " err after reset"}, int'(err_o[sel]), 0);
                check({tag, " done after reset"}, int'(done_o[sel]), 0);
                RN = 1'b1;
                return;
            end
            start_i[sel] = (k == restart_at);
            if (done_o[sel]) begin
                done_at = k;
                break;
            end
            if (!busy_o[sel] || int'(vec_o[sel]) != (k / (SETTLE + 1)) % 16) verr++;
            @(negedge CK);
        end
        start_i[sel] = 1'b0;
`ifdef OAI22_BIST_FIRST_FAIL_EN
        ffx = exp_ff;
`else
        ffx = 0;
`endif
        check({tag, " done latency"}, done_at, n);
        check({tag, " vector sequence errors"}, verr, 0);
        check({tag, " err_count"}, int'(err_o[sel]), exp_err);
        check({tag, " pass"}, int'(pass_o[sel]), exp_pass);
        check({tag, " first_fail"}, int'(ff_o[sel]), ffx);
        check({tag, " busy in done"}, int'(busy_o[sel]), 0);
        check({tag, " drive in done"}, int'(vec_o[sel]), 0);
    endtask

    initial begin
        int e;
        int f;
        int p;
        int sel;
        logic [15:0] t;

        tbl[0] = '{0, 16'h111F, -1, -1, 0, 0, 1, "golden"};
        tbl[1] = '{0, 16'h0000, -1, -1, 7, 0, 0, "stuck0"};
        tbl[2] = '{0, 16'hFFFF, -1, -1, 9, 5, 0, "stuck1"};
        tbl[3] = '{1, 16'h0000, -1, -1, 3, 0, 0, "sat_2pass"};
        tbl[4] = '{0, 16'hFFFF, 10, -1, 9, 5, 0, "start_while_busy"};
        tbl[5] = '{0, 16'h0000, -1, 19, 0, 0, 0, "abort_vec6"};
        tbl[6] = '{0, 16'h111F, -1, -1, 0, 0, 1, "after_abort"};

        RN      = 1'b0;
        start_i = 2'b00;
        tt[0]   = 16'h111F;
        tt[1]   = 16'h111F;
        repeat (3) @(negedge CK);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset busy%0d", s), int'(busy_o[s]), 0);
            check($sformatf("reset done%0d", s), int'(done_o[s]), 0);
            check($sformatf("reset pass%0d", s), int'(pass_o[s]), 0);
            check($sformatf("reset err%0d", s), int'(err_o[s]), 0);
            check($sformatf("reset first_fail%0d", s), int'(ff_o[s]), 0);
            check($sformatf("reset drive%0d", s), int'(vec_o[s]), 0);
        end
        RN = 1'b1;

        for (int i = 0; i < 7; i++)
            run(tbl[i].sel, tbl[i].t, tbl[i].restart_at, tbl[i].abort_at,
                tbl[i].exp_err, tbl[i].exp_ff, tbl[i].exp_pass, tbl[i].name);

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            if (i % 2 == 0) t = 16'($urandom);
            else t = 16'h111F ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if (i == 1) t = 16'h111F ^ 16'h8000;
            model(t, (sel == 1) ? 2 : 1, (sel == 1) ? 3 : 255, e, f, p);
            run(sel, t, -1, -1, e, f, p, $sformatf("rand%0d_dut%0d_tt%04h", i, sel, t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
